// File: rtl/adder_op_sequencer.sv
`timescale 1ns / 1ps
// adder_op_sequencer
//   Sequential wrapper around a combinational ripple adder. It accepts one operand
//   pair over a valid/ready handshake and registers it onto the adder inputs. It then
//   holds the operands for SETTLE_CYCLES edges while the carry chain ripples. Finally
//   it captures the sum and overflow flag and presents them on a valid/ready output.
//
// Parameters
//   WIDTH          operand width; the adder sum bus is WIDTH+1 bits
//   SETTLE_CYCLES  edges operands are held before the sum is sampled (1..15)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_cin         operand pair and carry-in
//   add_a, add_b, add_cin      registered operands driven to the adder
//   add_sum                    combinational sum returned by the adder
//   out_valid/out_ready        result handshake
//   out_sum                    captured unsigned sum, MSB is the carry-out
//   out_ovf                    two's-complement overflow of the captured add
module adder_op_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH:0]   add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("adder_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  // Counter is loaded with SETTLE_CYCLES-1 so the sample edge lands exactly
  // SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  state_e     state;
  logic [3:0] cnt;

  assign in_ready = (state == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= 4'd0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            add_a   <= in_a;
            add_b   <= in_b;
            add_cin <= in_cin;
            cnt     <= CntInit;
            state   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_sum   <= add_sum;
            // Overflow: like-signed operands producing a result of the other sign.
            out_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
